cont_tri_monitor: RTL and testbench

Downstream checker and display stage for the 4-bit triangle counter, which produces the sequence 0, 1, …, 15, 14, …, 0, 1, … on a shared Clock. It samples the counter output every cycle and locks onto the up/down direction. It validates every step, flags the turnaround points and counts complete periods. It also drives a registered 7-segment hex display of the sampled value.

---
 rtl/cont_tri_monitor_if.sv | 31 +++
 rtl/cont_tri_monitor.sv | 160 ++++++++++++++++
 tb/tb_cont_tri_monitor.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/cont_tri_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module   : cont_tri_monitor_if
//  Purpose  : Sample/status bundle between the triangle counter and its monitor.
//  Revision : 1.0  initial release
// ============================================================================
interface cont_tri_monitor_if #(
    parameter int PERIOD_W = 8
);
    logic [3:0]          In;
    logic                Locked;
    logic                Dir;
    logic                Peak;
    logic                Valley;
    logic [PERIOD_W-1:0] Periods;
    logic                Err;
    logic [6:0]          Seg;

    // Counter side: drives the sample and observes the monitor status.
    modport master (
        output In,
        input  Locked, Dir, Peak, Valley, Periods, Err, Seg
    );

    // Monitor side.
    modport slave (
        input  In,
        output Locked, Dir, Peak, Valley, Periods, Err, Seg
    );
endinterface
`default_nettype wire

// File: rtl/cont_tri_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : cont_tri_monitor
//  Purpose  : Tracks a 4-bit triangle counter, validates each step, flags the
//             turnarounds, counts periods and drives a 7-segment digit.
//  Revision : 1.0  initial release
// ============================================================================
module cont_tri_monitor #(
    parameter int PERIOD_W = 8
) (
    input  wire logic         Clock,
    input  wire logic         Reset,
    cont_tri_monitor_if.slave bus
);

    typedef enum logic [1:0] {
        INIT = 2'd0,
        LOCK = 2'd1,
        UP   = 2'd2,
        DOWN = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_prev;
    logic                r_dir;
    logic                w_dir_nxt;
    logic                r_peak;
    logic                w_peak_nxt;
    logic                r_valley;
    logic                w_valley_nxt;
    logic                r_err;
    logic                w_err_nxt;
    logic [PERIOD_W-1:0] r_periods;
    logic [PERIOD_W-1:0] w_periods_nxt;
    logic [6:0]          r_seg;
    logic [6:0]          w_seg_nxt;

    // Five-bit compare so that 15->0 and 0->15 never look like legal steps.
    logic [4:0] w_in5;
    logic [4:0] w_prev5;
    logic       w_step_up;
    logic       w_step_dn;
    logic       w_turn_peak;
    logic       w_turn_valley;

    assign w_in5         = {1'b0, bus.In};
    assign w_prev5       = {1'b0, r_prev};
    assign w_step_up     = (w_in5 == (w_prev5 + 5'd1));
    assign w_step_dn     = ((w_in5 + 5'd1) == w_prev5);
    assign w_turn_peak   = (r_prev == 4'd15) && (bus.In == 4'd14);
    assign w_turn_valley = (r_prev == 4'd0)  && (bus.In == 4'd1);

    always_comb begin
        w_state_nxt   = r_state;
        w_dir_nxt     = r_dir;
        w_peak_nxt    = 1'b0;
        w_valley_nxt  = 1'b0;
        w_err_nxt     = r_err;
        w_periods_nxt = r_periods;
        case (r_state)
            INIT: begin
                w_state_nxt = LOCK;
            end
            LOCK: begin
                if (w_step_up) begin
                    w_state_nxt = UP;
                    w_dir_nxt   = 1'b0;
                end else if (w_step_dn) begin
                    w_state_nxt = DOWN;
                    w_dir_nxt   = 1'b1;
                end
            end
            UP: begin
                if (w_step_up) begin
                    w_state_nxt = UP;
                end else if (w_turn_peak) begin
                    w_state_nxt = DOWN;
                    w_dir_nxt   = 1'b1;
                    w_peak_nxt  = 1'b1;
                end else begin
                    w_state_nxt = LOCK;
                    w_err_nxt   = 1'b1;
                end
            end
            DOWN: begin
                if (w_step_dn) begin
                    w_state_nxt = DOWN;
                end else if (w_turn_valley) begin
                    w_state_nxt   = UP;
                    w_dir_nxt     = 1'b0;
                    w_valley_nxt  = 1'b1;
                    w_periods_nxt = r_periods + 1'b1;
                end else begin
                    w_state_nxt = LOCK;
                    w_err_nxt   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = INIT;
            end
        endcase
    end

    // Hex digit decode, segments gfedcba, active-low.
    always_comb begin
        w_seg_nxt = 7'h40;
        case (bus.In)
            4'h0: w_seg_nxt = 7'h40;
            4'h1: w_seg_nxt = 7'h79;
            4'h2: w_seg_nxt = 7'h24;
            4'h3: w_seg_nxt = 7'h30;
            4'h4: w_seg_nxt = 7'h19;
            4'h5: w_seg_nxt = 7'h12;
            4'h6: w_seg_nxt = 7'h02;
            4'h7: w_seg_nxt = 7'h78;
            4'h8: w_seg_nxt = 7'h00;
            4'h9: w_seg_nxt = 7'h10;
            4'hA: w_seg_nxt = 7'h08;
            4'hB: w_seg_nxt = 7'h03;
            4'hC: w_seg_nxt = 7'h46;
            4'hD: w_seg_nxt = 7'h21;
            4'hE: w_seg_nxt = 7'h06;
            4'hF: w_seg_nxt = 7'h0E;
            default: w_seg_nxt = 7'h40;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state   <= INIT;
            r_prev    <= 4'd0;
            r_dir     <= 1'b0;
            r_peak    <= 1'b0;
            r_valley  <= 1'b0;
            r_err     <= 1'b0;
            r_periods <= '0;
            r_seg     <= 7'h40;
        end else begin
            r_state   <= w_state_nxt;
            r_prev    <= bus.In;
            r_dir     <= w_dir_nxt;
            r_peak    <= w_peak_nxt;
            r_valley  <= w_valley_nxt;
            r_err     <= w_err_nxt;
            r_periods <= w_periods_nxt;
            r_seg     <= w_seg_nxt;
        end
    end

    assign bus.Locked  = (r_state == UP) || (r_state == DOWN);
    assign bus.Dir     = r_dir;
    assign bus.Peak    = r_peak;
    assign bus.Valley  = r_valley;
    assign bus.Err     = r_err;
    assign bus.Periods = r_periods;
    assign bus.Seg     = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_cont_tri_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cont_tri_monitor
//  Purpose  : Directed scoreboard bench for cont_tri_monitor (PERIOD_W 8 and 2).
//  Revision : 1.0  initial release
// ============================================================================
module tb_cont_tri_monitor;

    logic Clock;
    logic Reset;

    cont_tri_monitor_if #(.PERIOD_W(8)) bus8 ();
    cont_tri_monitor_if #(.PERIOD_W(2)) bus2 ();

    assign bus2.In = bus8.In;

    cont_tri_monitor #(.PERIOD_W(8)) dut8 (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus8)
    );

    cont_tri_monitor #(.PERIOD_W(2)) dut2 (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus2)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [31:0] locked;
        logic [31:0] dir;
        logic [31:0] peak;
        logic [31:0] valley;
        logic [31:0] err;
        logic [31:0] p8;
        logic [31:0] p2;
        logic [31:0] seg;
    } exp_t;

    exp_t q[$];

    int nvec = 0;
    int nerr = 0;

    logic [6:0] segtbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model: 0=INIT 1=LOCK 2=UP 3=DOWN, integer prev so no mod-16 wrap.
    int m_state = 0;
    int m_prev  = 0;
    int m_dir   = 0;
    int m_err   = 0;
    int m_per   = 0;

    task automatic model(input int v, input bit rst, output exp_t e);
        int pk;
        int vl;
        pk = 0;
        vl = 0;
        if (rst) begin
            m_state = 0; m_prev = 0; m_dir = 0; m_err = 0; m_per = 0;
        end else begin
            case (m_state)
                0: m_state = 1;
                1: begin
                    if (v == m_prev + 1) begin m_state = 2; m_dir = 0; end
                    else if (v == m_prev - 1) begin m_state = 3; m_dir = 1; end
                end
                2: begin
                    if (v == m_prev + 1) m_state = 2;
                    else if (m_prev == 15 && v == 14) begin m_state = 3; m_dir = 1; pk = 1; end
                    else begin m_state = 1; m_err = 1; end
                end
                default: begin
                    if (v == m_prev - 1) m_state = 3;
                    else if (m_prev == 0 && v == 1) begin
                        m_state = 2; m_dir = 0; vl = 1; m_per = m_per + 1;
                    end else begin m_state = 1; m_err = 1; end
                end
            endcase
            m_prev = v;
        end
        e.locked = (m_state == 2 || m_state == 3) ? 1 : 0;
        e.dir    = m_dir;
        e.peak   = pk;
        e.valley = vl;
        e.err    = m_err;
        e.p8     = m_per % 256;
        e.p2     = m_per % 4;
        e.seg    = rst ? 32'h40 : {25'd0, segtbl[v]};
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step(input int v, input bit rst = 1'b0);
        exp_t e;
        bus8.In = 4'(v);
        Reset   = rst;
        model(v, rst, e);
        q.push_back(e);
        @(posedge Clock);
        #1;
        e = q.pop_front();
        chk($sformatf("locked@%0d", v), {31'd0, bus8.Locked}, e.locked);
        chk($sformatf("dir@%0d", v),    {31'd0, bus8.Dir},    e.dir);
        chk($sformatf("peak@%0d", v),   {31'd0, bus8.Peak},   e.peak);
        chk($sformatf("valley@%0d", v), {31'd0, bus8.Valley}, e.valley);
        chk($sformatf("err@%0d", v),    {31'd0, bus8.Err},    e.err);
        chk($sformatf("per8@%0d", v),   {24'd0, bus8.Periods}, e.p8);
        chk($sformatf("per2@%0d", v),   {30'd0, bus2.Periods}, e.p2);
        chk($sformatf("seg@%0d", v),    {25'd0, bus8.Seg},    e.seg);
        chk($sformatf("err2@%0d", v),   {31'd0, bus2.Err},    e.err);
    endtask

    task automatic ramp(input int a, input int b);
        if (a <= b) for (int i = a; i <= b; i++) step(i);
        else        for (int i = a; i >= b; i--) step(i);
    endtask

    task automatic period_from_one();
        ramp(2, 15);
        ramp(14, 0);
        step(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset   = 1'b1;
        bus8.In = 4'd0;
        step(0, 1'b1);
        step(0, 1'b1);
        chk("rst_seg", {25'd0, bus8.Seg}, 32'h40);
        chk("rst_locked", {31'd0, bus8.Locked}, 32'd0);

        // Clean start: lock on the 0->1 step.
        step(0);
        chk("init_unlocked", {31'd0, bus8.Locked}, 32'd0);
        step(1);
        chk("lock_up", {31'd0, bus8.Locked}, 32'd1);
        chk("seg_one", {25'd0, bus8.Seg}, 32'h79);
        ramp(2, 15);
        step(14);
        chk("peak_pulse", {31'd0, bus8.Peak}, 32'd1);
        chk("dir_down", {31'd0, bus8.Dir}, 32'd1);
        ramp(13, 0);
        step(1);
        chk("valley_pulse", {31'd0, bus8.Valley}, 32'd1);
        chk("periods_1", {24'd0, bus8.Periods}, 32'd1);

        period_from_one();
        period_from_one();
        chk("periods_3", {24'd0, bus8.Periods}, 32'd3);
        period_from_one();
        period_from_one();
        chk("periods_5", {24'd0, bus8.Periods}, 32'd5);
        chk("periods_w2_wrap", {30'd0, bus2.Periods}, 32'd1);

        // Skipped value.
        ramp(2, 6);
        step(8);
        chk("skip_err", {31'd0, bus8.Err}, 32'd1);
        chk("skip_unlock", {31'd0, bus8.Locked}, 32'd0);
        step(9);
        chk("relock_up", {31'd0, bus8.Locked}, 32'd1);

        // 15->0 wrap while locked.
        ramp(10, 15);
        step(0);
        chk("wrap_unlock", {31'd0, bus8.Locked}, 32'd0);
        chk("wrap_no_peak", {31'd0, bus8.Peak}, 32'd0);
        step(1);
        chk("wrap_no_valley", {31'd0, bus8.Valley}, 32'd0);

        // Repeated value while locked.
        ramp(2, 7);
        step(7);
        chk("repeat_unlock", {31'd0, bus8.Locked}, 32'd0);
        ramp(8, 15);
        ramp(14, 10);
        chk("err_sticky", {31'd0, bus8.Err}, 32'd1);

        // Reset mid-descent at 9, then reacquire.
        step(9, 1'b1);
        chk("mid_rst_seg", {25'd0, bus8.Seg}, 32'h40);
        chk("mid_rst_err", {31'd0, bus8.Err}, 32'd0);
        chk("mid_rst_per", {24'd0, bus8.Periods}, 32'd0);
        step(0);
        step(1);
        chk("relock_after_rst", {31'd0, bus8.Locked}, 32'd1);
        ramp(2, 4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
